// File: rtl/pkt_out_monitor.sv
// pkt_out_monitor: a 2-entry skid buffer between the SRAM FIFO controller and
// the output queues. It forwards the word stream unchanged, follows packet
// framing on the words that leave, and keeps packet/word/byte/error counters
// that the CPU can read and clear.
module pkt_out_monitor #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [9:0]            cpu_in_addr,
  input  logic [63:0]           cpu_in_data,
  input  logic                  cpu_in_wen,
  output logic [63:0]           cpu_out_data
);

  localparam logic [9:0]           CLR_ADDR       = 10'h100;
  localparam logic [CNT_WIDTH-1:0] BYTES_PER_WORD = CNT_WIDTH'(CTRL_WIDTH);

  // state    | meaning
  // WAIT_SOP | between packets; ctrl!=0 words are module headers
  // IN_PKT   | inside a packet; the next ctrl!=0 word is the EOP
  typedef enum logic {WAIT_SOP = 1'b0, IN_PKT = 1'b1} state_t;

  logic [1:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_data0, r_data1;
  logic [CTRL_WIDTH-1:0] r_ctrl0, r_ctrl1;
  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt, r_word_cnt, r_byte_cnt, r_err_cnt;

  logic                  w_push, w_pop, w_clr, w_onehot;
  logic                  w_word_inc, w_pkt_inc, w_err_inc;
  logic [CNT_WIDTH-1:0]  w_byte_add, w_eop_bytes;
  logic [63:0]           w_rd_data;
  logic                  w_unused_cpu_data;

  // Entry 0 is always the oldest word and drives the output directly.
  assign in_rdy   = (r_cnt != 2'd2);
  assign out_wr   = (r_cnt != 2'd0) & out_rdy;
  assign out_data = r_data0;
  assign out_ctrl = r_ctrl0;
  assign w_push   = in_wr & in_rdy;
  assign w_pop    = out_wr;
  assign w_clr    = cpu_in_wen & (cpu_in_addr == CLR_ADDR);
  assign w_unused_cpu_data = ^cpu_in_data;

  // Skid buffer storage and occupancy; a word offered while full is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= 2'd0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_ctrl0 <= '0;
      r_ctrl1 <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_data0 <= in_data;
            r_ctrl0 <= in_ctrl;
          end else begin
            r_data1 <= in_data;
            r_ctrl1 <= in_ctrl;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_ctrl0 <= r_ctrl1;
          r_cnt   <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_data0 <= in_data;
            r_ctrl0 <= in_ctrl;
          end else begin
            r_data0 <= r_data1;
            r_ctrl0 <= r_ctrl1;
            r_data1 <= in_data;
            r_ctrl1 <= in_ctrl;
          end
        end
        default: ;
      endcase
    end
  end

  // Framing state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= WAIT_SOP;
    else        r_state <= w_state_nxt;
  end

  // Framing next state, advanced only by words that actually leave.
  always_comb begin
    w_state_nxt = r_state;
    if (w_pop) begin
      case (r_state)
        WAIT_SOP: if (out_ctrl == '0) w_state_nxt = IN_PKT;
        IN_PKT:   if (out_ctrl != '0) w_state_nxt = WAIT_SOP;
        default:  w_state_nxt = WAIT_SOP;
      endcase
    end
  end

  // EOP byte count: one-hot bit i (LSB = 0) marks CTRL_WIDTH-i valid bytes.
  always_comb begin
    w_eop_bytes = '0;
    for (int i = 0; i < CTRL_WIDTH; i++)
      if (out_ctrl[i]) w_eop_bytes = CNT_WIDTH'(CTRL_WIDTH - i);
    w_onehot = (out_ctrl != '0) &&
               ((out_ctrl & (out_ctrl - CTRL_WIDTH'(1))) == '0);
  end

  // Framing outputs: counter increments for the word leaving this cycle.
  always_comb begin
    w_word_inc = w_pop;
    w_pkt_inc  = 1'b0;
    w_err_inc  = 1'b0;
    w_byte_add = '0;
    if (w_pop) begin
      if (out_ctrl == '0) begin
        w_byte_add = BYTES_PER_WORD;
      end else if (r_state == IN_PKT) begin
        w_pkt_inc = 1'b1;
        if (w_onehot) begin
          w_byte_add = w_eop_bytes;
        end else begin
          w_byte_add = BYTES_PER_WORD;
          w_err_inc  = 1'b1;
        end
      end
    end
  end

  // Statistics counters; a CPU clear beats any same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pkt_cnt  <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_clr) begin
      r_pkt_cnt  <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_pkt_cnt  <= r_pkt_cnt  + CNT_WIDTH'(w_pkt_inc);
      r_word_cnt <= r_word_cnt + CNT_WIDTH'(w_word_inc);
      r_byte_cnt <= r_byte_cnt + w_byte_add;
      r_err_cnt  <= r_err_cnt  + CNT_WIDTH'(w_err_inc);
    end
  end

  // CPU read mux; anything other than a read in this block's window returns 0.
  always_comb begin
    w_rd_data = '0;
    if (!cpu_in_wen && cpu_in_addr[9:8] == 2'b01) begin
      case (cpu_in_addr[1:0])
        2'd0:    w_rd_data[CNT_WIDTH-1:0] = r_pkt_cnt;
        2'd1:    w_rd_data[CNT_WIDTH-1:0] = r_word_cnt;
        2'd2:    w_rd_data[CNT_WIDTH-1:0] = r_byte_cnt;
        default: w_rd_data[CNT_WIDTH-1:0] = r_err_cnt;
      endcase
    end
  end

  assign cpu_out_data = w_rd_data;

endmodule

// File: tb/tb_pkt_out_monitor.sv
// Directed bench for pkt_out_monitor: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares every word the DUT emits, and
// counter values are checked against hand-computed numbers over the CPU port.
module tb_pkt_out_monitor;

  logic        clk, reset;
  logic [63:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic        in_wr, in_rdy, out_wr, out_rdy;
  logic [9:0]  cpu_in_addr;
  logic [63:0] cpu_in_data, cpu_out_data;
  logic        cpu_in_wen;

  logic [71:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        tog_en;
  int          acc;

  pkt_out_monitor #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .cpu_in_addr(cpu_in_addr), .cpu_in_data(cpu_in_data),
    .cpu_in_wen(cpu_in_wen), .cpu_out_data(cpu_out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every transferred word must be the oldest outstanding one.
  always @(negedge clk) begin
    if (reset && out_wr) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_word unexpected actual=0x%0h_%0h required=none", out_ctrl, out_data);
      end else begin
        logic [71:0] e;
        e = exp_q.pop_front();
        if ({out_ctrl, out_data} !== e) begin
          n_fail++;
          $display("FAIL out_word actual=0x%0h_%0h required=0x%0h_%0h",
                   out_ctrl, out_data, e[71:64], e[63:0]);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; waits (bounded) for space, then offers one word.
  task automatic send(input logic [63:0] d, input logic [7:0] c);
    int t = 0;
    while (!in_rdy && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!in_rdy) begin
      chk("send_timeout", 64'(in_rdy), 64'd1);
    end else begin
      in_data = d; in_ctrl = c; in_wr = 1'b1;
      exp_q.push_back({c, d});
      @(posedge clk); #1;
      in_wr = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); t++;
    end
    @(posedge clk); #1;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rd(input logic [9:0] a, input logic [63:0] e, input string nm);
    cpu_in_addr = a; cpu_in_wen = 1'b0;
    @(negedge clk);
    chk(nm, cpu_out_data, e);
  endtask

  task automatic rd_all(input logic [63:0] p, input logic [63:0] w,
                        input logic [63:0] b, input logic [63:0] e, input string tag);
    rd(10'h100, p, {tag, "_pkt"});
    rd(10'h101, w, {tag, "_word"});
    rd(10'h102, b, {tag, "_byte"});
    rd(10'h103, e, {tag, "_err"});
    sync();
  endtask

  initial begin
    clk = 0; reset = 0; in_data = '0; in_ctrl = '0; in_wr = 0; out_rdy = 1;
    cpu_in_addr = '0; cpu_in_data = '0; cpu_in_wen = 0; tog_en = 0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    reset = 1;
    sync();
    rd_all(0, 0, 0, 0, "rst");

    // Header, 3 data words, EOP with 4 valid bytes
    send(64'hAAAA_0000_0000_0001, 8'hFF);
    send(64'h1111_2222_3333_4444, 8'h00);
    send(64'h5555_6666_7777_8888, 8'h00);
    send(64'h9999_AAAA_BBBB_CCCC, 8'h00);
    send(64'hDDDD_EEEE_0000_0010, 8'h10);
    drain();
    rd_all(1, 5, 28, 0, "t1");

    // Backpressure: only two words fit, the third attempt is dropped
    out_rdy = 0; acc = 0;
    for (int i = 0; i < 3; i++) begin
      in_data = 64'h2000_0000_0000_0000 + 64'(i); in_ctrl = 8'h00; in_wr = 1'b1;
      if (in_rdy) begin
        exp_q.push_back({8'h00, in_data});
        acc++;
      end
      sync();
    end
    in_wr = 0;
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_in_rdy", 64'(in_rdy), 64'd0);
    chk("bp_out_wr", 64'(out_wr), 64'd0);
    out_rdy = 1;
    drain();
    chk("bp_in_rdy_back", 64'(in_rdy), 64'd1);

    // 64-word stream under toggling out_rdy; last word ends the packet
    tog_en = 1;
    fork
      begin
        for (int i = 0; i < 64; i++)
          send(64'h3000_0000_0000_0000 + 64'(i), (i == 63) ? 8'h01 : 8'h00);
        tog_en = 0;
      end
      begin
        while (tog_en) begin
          @(posedge clk); #1;
          out_rdy = ~out_rdy;
        end
      end
    join
    out_rdy = 1;
    drain();
    rd_all(2, 71, 556, 0, "t3");

    // Write to another block's address must not clear; 0x100 clears
    cpu_in_addr = 10'h200; cpu_in_wen = 1; sync(); cpu_in_wen = 0;
    rd(10'h100, 2, "foreign_wr_pkt");
    sync();
    cpu_in_addr = 10'h100; cpu_in_wen = 1; sync(); cpu_in_wen = 0;
    rd_all(0, 0, 0, 0, "clr");

    // Non-one-hot EOP, then a header proves the FSM is back in WAIT_SOP
    send(64'h4000_0000_0000_0001, 8'h00);
    send(64'h4000_0000_0000_0002, 8'h00);
    send(64'h4000_0000_0000_0003, 8'h11);
    drain();
    rd_all(1, 3, 24, 1, "t4");
    send(64'h4000_0000_0000_00FF, 8'hFF);
    drain();
    rd_all(1, 4, 24, 1, "t4_hdr");

    // Mid-traffic reads, then clear on the same edge as an EOP transfer
    send(64'h5000_0000_0000_0001, 8'h00);
    send(64'h5000_0000_0000_0002, 8'h00);
    drain();
    out_rdy = 0;
    send(64'h5000_0000_0000_0003, 8'h80);
    rd_all(1, 6, 40, 1, "t5_mid");
    out_rdy = 1; cpu_in_addr = 10'h100; cpu_in_wen = 1;
    #1;
    chk("t5_rd_during_wen", cpu_out_data, 64'd0);
    chk("t5_eop_out_wr", 64'(out_wr), 64'd1);
    sync();
    cpu_in_wen = 0;
    drain();
    rd_all(0, 0, 0, 0, "t5_clr");

    // Reset with two words buffered inside a packet
    send(64'h6000_0000_0000_0001, 8'h00);
    drain();
    out_rdy = 0;
    send(64'h6000_0000_0000_0002, 8'h00);
    send(64'h6000_0000_0000_0003, 8'h00);
    chk("t6_full", 64'(in_rdy), 64'd0);
    reset = 0; out_rdy = 1;
    exp_q.delete();
    #1;
    chk("t6_rst_out_wr", 64'(out_wr), 64'd0);
    chk("t6_rst_in_rdy", 64'(in_rdy), 64'd1);
    rd(10'h100, 0, "t6_rst_pkt");
    rd(10'h101, 0, "t6_rst_word");
    sync();
    reset = 1;
    sync();
    send(64'h7000_0000_0000_0001, 8'h02);
    send(64'h7000_0000_0000_0002, 8'h00);
    send(64'h7000_0000_0000_0003, 8'h40);
    drain();
    rd_all(1, 3, 10, 0, "t6_after");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_out_monitor.md
Name: pkt_out_monitor

Overview:
- Sits directly downstream of the SRAM FIFO controller in the user data path.
- Consumes its out_data/out_ctrl/out_wr stream through a 2-entry skid buffer and forwards the stream unchanged to the output queues.
- Tracks packet boundaries on the forwarded stream and keeps packet, word, byte and framing-error counters, readable and clearable over the CPU register interface.

Parameters:
- DATA_WIDTH, 64, data word width.
- CTRL_WIDTH, DATA_WIDTH/8, control width; one bit per byte lane.
- CNT_WIDTH, 32, width of each statistics counter (at most 64).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  in  DATA_WIDTH  word from the upstream FIFO.
- in_ctrl  in  CTRL_WIDTH  control for in_data.
- in_wr  in  1  upstream write strobe; legal only while in_rdy=1.
- in_rdy  out  1  buffer can accept a word this cycle.
- out_data  out  DATA_WIDTH  word to the downstream stage.
- out_ctrl  out  CTRL_WIDTH  control for out_data.
- out_wr  out  1  word transferred downstream this cycle.
- out_rdy  in  1  downstream can accept a word this cycle.
- cpu_in_addr  in  10  register address.
- cpu_in_data  in  64  write data; value ignored, writes are strobes.
- cpu_in_wen  in  1  register write enable.
- cpu_out_data  out  64  combinational register read data.

Behaviour:
- Reset:
  - Buffer occupancy = 0; FSM = WAIT_SOP; all counters = 0.
  - out_wr = 0, in_rdy = 1, out_data/out_ctrl = 0.
  - Reset asserted mid-packet drops buffered words; no partial counts are retained.
- Skid buffer: 2 entries, registered occupancy cnt in 0..2.
  - in_rdy = (cnt != 2), driven from the register.
  - out_data/out_ctrl = oldest entry, registered.
  - out_wr = (cnt != 0) & out_rdy.
  - Write and read in the same cycle: cnt unchanged; order preserved.
  - Latency: a word accepted at edge N is presented on out_data after edge N and can leave at cycle N+1.
  - in_wr while in_rdy=0 is a protocol violation: the word is ignored and cnt never exceeds 2.
- Framing FSM, advanced only on transferred words (out_wr=1):
  - WAIT_SOP, word with ctrl != 0: module header; stay in WAIT_SOP; word_count += 1.
  - WAIT_SOP, word with ctrl == 0: first packet word; go to IN_PKT; word_count += 1; byte_count += 8.
  - IN_PKT, word with ctrl == 0: word_count += 1; byte_count += 8.
  - IN_PKT, word with ctrl != 0: EOP; word_count += 1; pkt_count += 1; return to WAIT_SOP.
- EOP byte rule: valid bytes = 1 for ctrl 0x80, 2 for 0x40, 3 for 0x20, 4 for 0x10, 5 for 0x08, 6 for 0x04, 7 for 0x02, 8 for 0x01. byte_count += that value.
- Non-one-hot EOP ctrl: byte_count += 8, err_count += 1; still counted as EOP.
- Counters: CNT_WIDTH bits, wrap modulo 2^CNT_WIDTH.
- CPU clear:
  - Write (cpu_in_wen=1) to address 0x100 clears all four counters at the next edge.
  - Clear wins over a same-cycle increment.
  - FSM and buffer are unaffected.
- CPU reads, valid when cpu_in_wen=0 and cpu_in_addr[9:8]=2'b01, zero-extended to 64 bits:
  - offset [1:0]=0: pkt_count.
  - offset 1: word_count.
  - offset 2: byte_count.
  - offset 3: err_count.
  - Any other address, or cpu_in_wen=1: cpu_out_data = 0.
  - Addresses outside [9:8]=2'b01 belong to other blocks and are ignored for writes.

Test Plan:
- Reset release, out_rdy=1. Send 1 module header (ctrl 0xFF), 3 data words (ctrl 0), EOP word with ctrl 0x10. Required: 5 out_wr pulses with the same data in order; pkt=1, word=5, byte=28, err=0.
- out_rdy=0, 3 back-to-back in_wr attempts. Required: in_rdy falls after 2 accepted words; cnt=2; no out_wr. Then out_rdy=1: both words emitted in order and in_rdy returns to 1.
- out_rdy toggling 1/0 each cycle with continuous writes under in_rdy. Required: no word lost or duplicated over a 64-word stream (scoreboard match).
- EOP ctrl 0x11 after 2 data words. Required: err=1, byte=24, pkt=1, FSM back in WAIT_SOP.
- Read 0x100-0x103 mid-traffic, then write 0x100 in the same cycle as an EOP transfer. Required: all counters read 0 afterward, including the EOP increment.
- Assert reset with cnt=2 in IN_PKT. Required: out_wr=0, in_rdy=1, all counters 0; the next packet is counted normally from WAIT_SOP.
